// File: rtl/tk1_led_pkg.sv
// rtl/tk1_led_pkg.sv - register map, ctrl bit positions and FSM states for the RGB LED PWM block
package tk1_led_pkg;

    localparam logic [1:0] ADDR_R    = 2'd0;
    localparam logic [1:0] ADDR_G    = 2'd1;
    localparam logic [1:0] ADDR_B    = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_BLINK = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN_ON  = 2'd1,
        ST_RUN_OFF = 2'd2
    } led_state_t;

endpackage

// File: rtl/tk1_led_pwm_chan.sv
// rtl/tk1_led_pwm_chan.sv - one PWM channel: shadow/active duty, comparator and output flop
module tk1_led_pwm_chan (
    input  logic       clk,
    input  logic       reset,   // synchronous, active-high
    input  logic       we,      // shadow duty write strobe
    input  logic [7:0] wdata,   // shadow duty write data
    input  logic       load,    // copy shadow into active this cycle
    input  logic       run_on,  // PWM output allowed
    input  logic [7:0] count,   // shared step counter
    output logic [7:0] shadow,  // shadow duty for readback
    output logic       pwm      // registered PWM output
);

    logic [7:0] active;

    // load samples the pre-write shadow, so a write coinciding with a
    // boundary only takes effect at the following boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= 8'd0;
            active <= 8'd0;
            pwm    <= 1'b0;
        end else begin
            if (we) begin
                shadow <= wdata;
            end
            if (load) begin
                active <= shadow;
            end
            pwm <= run_on && (count < active);
        end
    end

endmodule

// File: rtl/tk1_led_pwm.sv
// rtl/tk1_led_pwm.sv - RGB LED PWM top: registers, prescaler, step counter, blink FSM
module tk1_led_pwm #(
    parameter int PRESCALE      = 4,   // clk cycles per PWM step, >= 1
    parameter int BLINK_PERIODS = 64   // PWM periods per blink phase, >= 1
) (
    input  logic       clk,
    input  logic       reset,         // synchronous, active-high
    input  logic       cfg_we,        // register write strobe
    input  logic [1:0] cfg_addr,      // 0=R 1=G 2=B 3=ctrl
    input  logic [7:0] cfg_wdata,     // register write data
    output logic [7:0] cfg_rdata,     // combinational readback
    output logic [2:0] rgb_pwm,       // [0]=R [1]=G [2]=B
    output logic       led_en,        // registered ctrl.enable
    output logic       curr_en,       // registered ctrl.enable
    output logic       period_start   // one-cycle pulse per PWM period boundary
);

    import tk1_led_pkg::*;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_PERIODS - 1);

    led_state_t    state;
    led_state_t    state_nxt;
    logic          ctrl_en;
    logic          ctrl_blink;
    logic [PW-1:0] presc;
    logic [7:0]    counter;
    logic [BW-1:0] blink_cnt;
    logic          running;
    logic          tick;
    logic          boundary;
    logic          blink_wrap;
    logic          run_on;
    logic          load;
    logic [2:0]    we_chan;
    logic [7:0]    shadow_r;
    logic [7:0]    shadow_g;
    logic [7:0]    shadow_b;

    assign running    = (state != ST_IDLE);
    assign tick       = running && (presc == PRESC_MAX);
    assign boundary   = tick && (counter == 8'hFF);
    assign blink_wrap = boundary && ctrl_blink && (blink_cnt == BLINK_MAX);
    // ctrl_en gating drops the outputs one cycle ahead of the IDLE transition
    assign run_on     = (state == ST_RUN_ON) && ctrl_en;
    // while idle the active duties simply follow their shadows
    assign load       = !running || boundary;

    assign we_chan[0] = cfg_we && (cfg_addr == ADDR_R);
    assign we_chan[1] = cfg_we && (cfg_addr == ADDR_G);
    assign we_chan[2] = cfg_we && (cfg_addr == ADDR_B);

    always_comb begin
        cfg_rdata = 8'd0;
        case (cfg_addr)
            ADDR_R:    cfg_rdata = shadow_r;
            ADDR_G:    cfg_rdata = shadow_g;
            ADDR_B:    cfg_rdata = shadow_b;
            default:   cfg_rdata = {6'd0, ctrl_blink, ctrl_en};
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ctrl_en) state_nxt = ST_RUN_ON;
            end
            ST_RUN_ON: begin
                if (!ctrl_en)        state_nxt = ST_IDLE;
                else if (blink_wrap) state_nxt = ST_RUN_OFF;
            end
            ST_RUN_OFF: begin
                if (!ctrl_en)         state_nxt = ST_IDLE;
                else if (!ctrl_blink) state_nxt = ST_RUN_ON;
                else if (blink_wrap)  state_nxt = ST_RUN_ON;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            ctrl_en      <= 1'b0;
            ctrl_blink   <= 1'b0;
            presc        <= '0;
            counter      <= 8'd0;
            blink_cnt    <= '0;
            led_en       <= 1'b0;
            curr_en      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            state        <= state_nxt;
            led_en       <= ctrl_en;
            curr_en      <= ctrl_en;
            period_start <= boundary && ctrl_en;
            if (cfg_we && (cfg_addr == ADDR_CTRL)) begin
                ctrl_en    <= cfg_wdata[CTRL_EN];
                ctrl_blink <= cfg_wdata[CTRL_BLINK];
            end
            if (!running) begin
                presc     <= '0;
                counter   <= 8'd0;
                blink_cnt <= '0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    counter <= counter + 8'd1;
                end
                if (!ctrl_blink) begin
                    blink_cnt <= '0;
                end else if (boundary) begin
                    blink_cnt <= (blink_cnt == BLINK_MAX) ? '0 : blink_cnt + 1'b1;
                end
            end
        end
    end

    tk1_led_pwm_chan u_chan_r (
        .clk(clk), .reset(reset), .we(we_chan[0]), .wdata(cfg_wdata), .load(load),
        .run_on(run_on), .count(counter), .shadow(shadow_r), .pwm(rgb_pwm[0])
    );

    tk1_led_pwm_chan u_chan_g (
        .clk(clk), .reset(reset), .we(we_chan[1]), .wdata(cfg_wdata), .load(load),
        .run_on(run_on), .count(counter), .shadow(shadow_g), .pwm(rgb_pwm[1])
    );

    tk1_led_pwm_chan u_chan_b (
        .clk(clk), .reset(reset), .we(we_chan[2]), .wdata(cfg_wdata), .load(load),
        .run_on(run_on), .count(counter), .shadow(shadow_b), .pwm(rgb_pwm[2])
    );

endmodule
